narrow_to_wide_fifo: RTL

Synchronous FIFO that accepts narrow subwords and delivers wide words. Each wide entry is assembled from `OUTPUT_WIDTH/INPUT_WIDTH` consecutive pushes. It is the write-side counterpart of the wide-in/narrow-out FIFO on the belief-propagation datapath: it gathers per-cycle narrow message fragments into full-width RAM words for the sequential update engine.

---
 rtl/narrow_to_wide_fifo_pkg.sv | 29 ++
 rtl/narrow_to_wide_fifo_if.sv | 50 +++++
 rtl/narrow_to_wide_fifo_subword_packer.sv | 55 +++++
 rtl/narrow_to_wide_fifo.sv | 85 ++++++++
 4 files changed

// File: rtl/narrow_to_wide_fifo_pkg.sv
// Shared sizing helpers for the narrow/wide FIFO pair: clog2, subword ratio, lane and pointer widths.
package narrow_to_wide_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int width_ratio(input int narrow_w, input int wide_w);
    return wide_w / narrow_w;
  endfunction

  function automatic int lane_bits(input int ratio);
    return clog2(ratio);
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/narrow_to_wide_fifo_if.sv
// Push/pop bus of the narrow-in, wide-out FIFO. The flush wire exists only when
// NARROW_TO_WIDE_FIFO_FLUSH_EN is defined.
interface narrow_to_wide_fifo_if #(
  parameter int INPUT_WIDTH  = 4,
  parameter int OUTPUT_WIDTH = 8,
  parameter int DEPTH        = 6
);
  logic                    push;
  logic                    pop;
`ifdef NARROW_TO_WIDE_FIFO_FLUSH_EN
  logic                    flush;
`endif
  logic [INPUT_WIDTH-1:0]  d;
  logic [OUTPUT_WIDTH-1:0] q;
  logic                    full;
  logic                    empty;
  logic [DEPTH:0]          count;
  logic                    almost_empty;
  logic                    almost_full;

  modport master (
    output push,
    output pop,
`ifdef NARROW_TO_WIDE_FIFO_FLUSH_EN
    output flush,
`endif
    output d,
    input  q,
    input  full,
    input  empty,
    input  count,
    input  almost_empty,
    input  almost_full
  );

  modport slave (
    input  push,
    input  pop,
`ifdef NARROW_TO_WIDE_FIFO_FLUSH_EN
    input  flush,
`endif
    input  d,
    output q,
    output full,
    output empty,
    output count,
    output almost_empty,
    output almost_full
  );
endinterface

// File: rtl/narrow_to_wide_fifo_subword_packer.sv
// Gathers narrow subwords into one wide word, lowest lane first, and strobes commit when
// the word is complete (or, with NARROW_TO_WIDE_FIFO_FLUSH_EN, when a partial word is flushed).
module subword_packer
  import narrow_to_wide_fifo_pkg::*;
#(
  parameter int INPUT_WIDTH  = 4,
  parameter int OUTPUT_WIDTH = 8,
  parameter int WIDTH_RATIO  = width_ratio(INPUT_WIDTH, OUTPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept,
  input  logic [INPUT_WIDTH-1:0]  d,
`ifdef NARROW_TO_WIDE_FIFO_FLUSH_EN
  input  logic                    flush,
  input  logic                    full,
`endif
  output logic                    commit,
  output logic [OUTPUT_WIDTH-1:0] word
);
  localparam int LANE_BITS = lane_bits(WIDTH_RATIO);
  localparam int STAGE_W   = OUTPUT_WIDTH - INPUT_WIDTH;

  logic [LANE_BITS-1:0]    lane;
  logic [STAGE_W-1:0]      staging;
  logic                    last_lane;
  logic [OUTPUT_WIDTH-1:0] fresh;

  assign last_lane = (lane == LANE_BITS'(WIDTH_RATIO - 1));
  assign fresh     = accept ? (OUTPUT_WIDTH'(d) << (lane * INPUT_WIDTH)) : '0;

  // Staging is cleared on every commit, so lanes at or above `lane` are already zero and
  // the same expression yields both the full word and a zero-padded flushed word.
  assign word = {{INPUT_WIDTH{1'b0}}, staging} | fresh;

`ifdef NARROW_TO_WIDE_FIFO_FLUSH_EN
  assign commit = (accept && last_lane) || (flush && !full && ((lane != '0) || accept));
`else
  assign commit = accept && last_lane;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane    <= '0;
      staging <= '0;
    end else if (commit) begin
      lane    <= '0;
      staging <= '0;
    end else if (accept) begin
      lane    <= lane + 1'b1;
      staging <= staging | fresh[STAGE_W-1:0];
    end
  end

endmodule

// File: rtl/narrow_to_wide_fifo.sv
// Narrow-in, wide-out synchronous FIFO: pointers, RAM, registered read data and occupancy flags.
// Optional flush of a partial entry is enabled by NARROW_TO_WIDE_FIFO_FLUSH_EN.
module narrow_to_wide_fifo
  import narrow_to_wide_fifo_pkg::*;
#(
  parameter int INPUT_WIDTH        = 4,
  parameter int OUTPUT_WIDTH       = 8,
  parameter int DEPTH              = 6,
  parameter int ALMOST_EMPTY_COUNT = 1,
  parameter int ALMOST_FULL_COUNT  = 1,
  parameter int WIDTH_RATIO        = width_ratio(INPUT_WIDTH, OUTPUT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  narrow_to_wide_fifo_if.slave  bus
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(2 ** DEPTH);
  localparam logic [PTR_W-1:0] AE_LIM   = PTR_W'(1 + ALMOST_EMPTY_COUNT);
  localparam logic [PTR_W-1:0] AF_LIM   = PTR_W'(2 ** DEPTH - 1 - ALMOST_FULL_COUNT);

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        count;
  logic [OUTPUT_WIDTH-1:0] ram [2 ** DEPTH];
  logic [OUTPUT_WIDTH-1:0] q_p1;
  logic [OUTPUT_WIDTH-1:0] word;
  logic                    commit;
  logic                    push_ok;
  logic                    pop_ok;
  logic                    full;
  logic                    empty;

  assign push_ok = bus.push && !full;
  assign pop_ok  = bus.pop && !empty;

  subword_packer #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .WIDTH_RATIO  (WIDTH_RATIO)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .accept (push_ok),
    .d      (bus.d),
`ifdef NARROW_TO_WIDE_FIFO_FLUSH_EN
    .flush  (bus.flush),
    .full   (full),
`endif
    .commit (commit),
    .word   (word)
  );

  // Stage p0 -> p1: pointer update and registered read of the head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_p1   <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        q_p1   <= ram[rd_ptr[DEPTH-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) ram[wr_ptr[DEPTH-1:0]] <= word;
  end

  // Flags depend only on registered pointers, never on push/pop.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign bus.q            = q_p1;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_empty = (count < AE_LIM);
  assign bus.almost_full  = (count > AF_LIM);

endmodule
